// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: one outstanding imem request,
// holds the fetched word for decode, and squashes in-flight fetches on exceptions.
//
// state   | meaning
// FETCH   | requesting imem at pc, waiting for ack
// HOLD    | inst valid, waiting for decode to take it
// DRAIN   | squashed request still outstanding at old_addr; data is discarded
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  npc_sel_i,
  input  logic [15:0] branch_off_i,
  input  logic [31:0] jtarget_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] epc_i,
  input  logic        exc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_take_i,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] old_addr_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] npc_d;

  always_comb begin
    seq_pc = inst_pc_q + 32'd4;
    br_off = {{14{branch_off_i[15]}}, branch_off_i, 2'b00};
    npc_d  = seq_pc;
    case (npc_sel_i)
      3'd1:    npc_d = seq_pc + br_off;
      3'd2:    npc_d = jtarget_i;
      3'd3:    npc_d = rs_val_i;
      3'd4:    npc_d = epc_i;
      default: npc_d = seq_pc;
    endcase
    npc_d[1:0] = 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      old_addr_q   <= 32'd0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (exc_i) begin
            pc_q <= EXC_VECTOR;
            // Without ack the request at pc is still in flight and must be drained.
            if (!imem_ack_i) begin
              old_addr_q <= pc_q;
              state_q    <= S_DRAIN;
            end
          end else if (imem_ack_i) begin
            inst_q       <= imem_rdata_i;
            inst_pc_q    <= pc_q;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (exc_i) begin
            pc_q         <= EXC_VECTOR;
            inst_valid_q <= 1'b0;
            state_q      <= S_FETCH;
          end else if (inst_take_i) begin
            pc_q         <= npc_d;
            inst_valid_q <= 1'b0;
            state_q      <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (exc_i) pc_q <= EXC_VECTOR;
          if (imem_ack_i) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_req_o   = !rst_i && (state_q == S_FETCH || state_q == S_DRAIN);
  assign imem_addr_o  = (state_q == S_DRAIN) ? old_addr_q : pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: table of fetch/take vectors plus hand-written
// exception, drain and reset sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  npc_sel = 3'd0;
  logic [15:0] branch_off = 16'd0;
  logic [31:0] jtarget = 32'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] epc = 32'd0;
  logic        exc = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_take = 1'b0;
  logic [31:0] pc;

  int n_pass = 0;
  int n_total = 0;

  pc_fetch_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .npc_sel_i    (npc_sel),
    .branch_off_i (branch_off),
    .jtarget_i    (jtarget),
    .rs_val_i     (rs_val),
    .epc_i        (epc),
    .exc_i        (exc),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (inst_valid),
    .inst_take_i  (inst_take),
    .pc_o         (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic [31:0] addr;   // address expected to be fetched
    logic [2:0]  sel;    // npc_sel applied on take
    logic [15:0] boff;
    logic [31:0] jt;
    logic [31:0] rs;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{32'h0040_0000, 3'd0, 16'h0000, 32'h0,         32'h0,         32'h0};
    vecs[1]  = '{32'h0040_0004, 3'd0, 16'h0000, 32'h0,         32'h0,         32'h0};
    vecs[2]  = '{32'h0040_0008, 3'd2, 16'h0000, 32'h0040_0010, 32'h0,         32'h0};
    vecs[3]  = '{32'h0040_0010, 3'd1, 16'hFFFC, 32'h0,         32'h0,         32'h0};
    vecs[4]  = '{32'h0040_0004, 3'd2, 16'h0000, 32'h0040_0010, 32'h0,         32'h0};
    vecs[5]  = '{32'h0040_0010, 3'd1, 16'h0003, 32'h0,         32'h0,         32'h0};
    vecs[6]  = '{32'h0040_0020, 3'd2, 16'h0000, 32'h0040_0100, 32'h0,         32'h0};
    vecs[7]  = '{32'h0040_0100, 3'd3, 16'h0000, 32'h0,         32'h0040_0203, 32'h0};
    vecs[8]  = '{32'h0040_0200, 3'd4, 16'h0000, 32'h0,         32'h0,         32'h0040_0040};
    vecs[9]  = '{32'h0040_0040, 3'd7, 16'h0000, 32'h1111_1110, 32'h0,         32'h0};
    vecs[10] = '{32'h0040_0044, 3'd2, 16'h0000, 32'hFFFF_FFFC, 32'h0,         32'h0};
    vecs[11] = '{32'hFFFF_FFFC, 3'd0, 16'h0000, 32'h0,         32'h0,         32'h0};
    vecs[12] = '{32'h0000_0000, 3'd2, 16'h0000, 32'h0040_000B, 32'h0,         32'h0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 13; i++) begin
      logic [31:0] word;
      word = vecs[i].addr ^ 32'hA5A5_0000;
      chk("vec_req", {31'd0, imem_req}, 32'd1);
      chk("vec_addr", imem_addr, vecs[i].addr);
      chk("vec_valid_lo", {31'd0, inst_valid}, 32'd0);
      imem_ack = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("vec_valid_hi", {31'd0, inst_valid}, 32'd1);
      chk("vec_inst", inst, word);
      chk("vec_inst_pc", inst_pc, vecs[i].addr);
      chk("vec_hold_req", {31'd0, imem_req}, 32'd0);
      inst_take = 1'b1;
      npc_sel = vecs[i].sel;
      branch_off = vecs[i].boff;
      jtarget = vecs[i].jt;
      rs_val = vecs[i].rs;
      epc = vecs[i].ep;
      @(negedge clk);
      inst_take = 1'b0;
      npc_sel = 3'd0;
    end

    // exception in FETCH at 0x00400008, ack delayed 3 cycles
    chk("exc_f_addr0", imem_addr, 32'h0040_0008);
    exc = 1'b1;
    @(negedge clk);
    exc = 1'b0;
    chk("drain_pc", pc, 32'h0040_0004);
    for (int c = 0; c < 3; c++) begin
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      chk("drain_addr", imem_addr, 32'h0040_0008);
      chk("drain_valid", {31'd0, inst_valid}, 32'd0);
      if (c == 2) begin
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("post_drain_valid", {31'd0, inst_valid}, 32'd0);
    chk("post_drain_addr", imem_addr, 32'h0040_0004);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("vec_inst_exc", inst, 32'h1234_5678);
    chk("vec_inst_pc_exc", inst_pc, 32'h0040_0004);
    chk("vec_valid_exc", {31'd0, inst_valid}, 32'd1);

    // ack in HOLD is ignored
    imem_ack = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("hold_ack_inst", inst, 32'h1234_5678);
    chk("hold_ack_valid", {31'd0, inst_valid}, 32'd1);

    // exc and take together in HOLD: exception wins
    inst_take = 1'b1;
    exc = 1'b1;
    npc_sel = 3'd2;
    jtarget = 32'h0040_0100;
    @(negedge clk);
    inst_take = 1'b0;
    exc = 1'b0;
    chk("exc_take_pc", pc, 32'h0040_0004);
    chk("exc_take_valid", {31'd0, inst_valid}, 32'd0);
    chk("exc_take_addr", imem_addr, 32'h0040_0004);

    // move to 0x00400100, then exc with ack in the same FETCH cycle
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    inst_take = 1'b1;
    @(negedge clk);
    inst_take = 1'b0;
    chk("jump_addr", imem_addr, 32'h0040_0100);
    exc = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    exc = 1'b0;
    imem_ack = 1'b0;
    chk("exc_ack_valid", {31'd0, inst_valid}, 32'd0);
    chk("exc_ack_req", {31'd0, imem_req}, 32'd1);
    chk("exc_ack_addr", imem_addr, 32'h0040_0004);

    // take without a valid inst is ignored
    inst_take = 1'b1;
    jtarget = 32'h0040_0800;
    @(negedge clk);
    inst_take = 1'b0;
    chk("idle_take_pc", pc, 32'h0040_0004);

    // reset during DRAIN
    exc = 1'b1;
    @(negedge clk);
    exc = 1'b0;
    @(negedge clk);
    chk("drain2_addr", imem_addr, 32'h0040_0004);
    rst = 1'b1;
    #1;
    chk("rst_drain_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("rst_drain_pc", pc, 32'h0040_0000);
    chk("rst_drain_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_drain_req2", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_req", {31'd0, imem_req}, 32'd1);
    chk("rst_release_addr", imem_addr, 32'h0040_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
